// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between two requesters.
// Operands are latched on accept; results return on a valid/ready channel tagged with the requester id.
module alu_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req0_data1_i,
    input  logic [WIDTH-1:0] req0_data2_i,
    input  logic [2:0]       req0_ctrl_i,

    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req1_data1_i,
    input  logic [WIDTH-1:0] req1_data2_i,
    input  logic [2:0]       req1_ctrl_i,

    output logic [WIDTH-1:0] alu_data1_o,
    output logic [WIDTH-1:0] alu_data2_o,
    output logic [2:0]       alu_ctrl_o,
    input  logic [WIDTH-1:0] alu_data_i,

    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             rsp_err_o,
    output logic             busy_o
);

    localparam logic [2:0] CTRL_AND = 3'b000;
    localparam logic [2:0] CTRL_OR  = 3'b001;
    localparam logic [2:0] CTRL_ADD = 3'b010;
    localparam logic [2:0] CTRL_SUB = 3'b110;
    localparam logic [2:0] CTRL_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             ptr;
    logic             op_id;
    logic             op_err;
    logic [3:0]       cnt;

    logic             grant;
    logic             accept;
    logic [WIDTH-1:0] sel_data1;
    logic [WIDTH-1:0] sel_data2;
    logic [2:0]       sel_ctrl;
    logic             sel_legal;
    logic [3:0]       sel_lat_m1;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant = 1'b0;
        if (ptr) begin
            grant = req1_valid_i ? 1'b1 : 1'b0;
        end else begin
            grant = req0_valid_i ? 1'b0 : 1'b1;
        end
        accept       = (state == IDLE) && (req0_valid_i || req1_valid_i);
        req0_ready_o = accept && !grant;
        req1_ready_o = accept && grant;

        sel_data1 = grant ? req1_data1_i : req0_data1_i;
        sel_data2 = grant ? req1_data2_i : req0_data2_i;
        sel_ctrl  = grant ? req1_ctrl_i  : req0_ctrl_i;

        sel_legal = 1'b0;
        case (sel_ctrl)
            CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB, CTRL_MUL: sel_legal = 1'b1;
            default:                                         sel_legal = 1'b0;
        endcase
        sel_lat_m1 = (sel_ctrl == CTRL_MUL) ? 4'(MUL_LAT - 1) : 4'd0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: only control/output registers are reset; there is no memory here that would need leaving unreset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr         <= 1'b0;
            op_id       <= 1'b0;
            op_err      <= 1'b0;
            cnt         <= 4'd0;
            alu_data1_o <= '0;
            alu_data2_o <= '0;
            alu_ctrl_o  <= 3'b000;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= 1'b0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_data1_o <= sel_data1;
                        alu_data2_o <= sel_data2;
                        // Illegal codes still occupy one EXEC cycle on a harmless add.
                        alu_ctrl_o  <= sel_legal ? sel_ctrl : CTRL_ADD;
                        op_err      <= !sel_legal;
                        op_id       <= grant;
                        cnt         <= sel_lat_m1;
                        ptr         <= ~grant;
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_data_o  <= op_err ? '0 : alu_data_i;
                        rsp_err_o   <= op_err;
                        rsp_id_o    <= op_id;
                        rsp_valid_o <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) rsp_valid_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU on the shared port, scoreboard of expected responses.
// Scenario tasks add their own timing and protocol comparisons.
module tb_alu_share_arbiter;

    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready;
    logic [WIDTH-1:0] req0_data1, req0_data2;
    logic [2:0]       req0_ctrl;
    logic             req1_valid, req1_ready;
    logic [WIDTH-1:0] req1_data1, req1_data2;
    logic [2:0]       req1_ctrl;
    logic [WIDTH-1:0] alu_data1, alu_data2, alu_result;
    logic [2:0]       alu_ctrl;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [WIDTH-1:0] rsp_data;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] data;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;
    int   cyc    = 0;

    alu_share_arbiter #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_data1_i (req0_data1),
        .req0_data2_i (req0_data2),
        .req0_ctrl_i  (req0_ctrl),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_data1_i (req1_data1),
        .req1_data2_i (req1_data2),
        .req1_ctrl_i  (req1_ctrl),
        .alu_data1_o  (alu_data1),
        .alu_data2_o  (alu_data2),
        .alu_ctrl_o   (alu_ctrl),
        .alu_data_i   (alu_result),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_data_o   (rsp_data),
        .rsp_err_o    (rsp_err),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared combinational ALU seen by the arbiter; unknown codes return a marker value.
    always_comb begin
        alu_result = 32'hDEAD_BEEF;
        case (alu_ctrl)
            3'b000: alu_result = alu_data1 & alu_data2;
            3'b001: alu_result = alu_data1 | alu_data2;
            3'b010: alu_result = alu_data1 + alu_data2;
            3'b110: alu_result = alu_data1 - alu_data2;
            3'b111: alu_result = alu_data1 * alu_data2;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    function automatic exp_t model(input logic id, input logic [2:0] c,
                                   input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        e.id  = id;
        e.err = 1'b0;
        e.data = '0;
        case (c)
            3'b000: e.data = a & b;
            3'b001: e.data = a | b;
            3'b010: e.data = a + b;
            3'b110: e.data = a - b;
            3'b111: e.data = a * b;
            default: begin
                e.data = '0;
                e.err  = 1'b1;
            end
        endcase
        return e;
    endfunction

    // Scoreboard: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_valid && req0_ready) sb.push_back(model(1'b0, req0_ctrl, req0_data1, req0_data2));
            if (req1_valid && req1_ready) sb.push_back(model(1'b1, req1_ctrl, req1_data1, req1_data2));
            if (rsp_valid && rsp_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    failed++;
                    $display("FAIL rsp_unexpected: got id=%0d data=%h err=%0d, required no response",
                             rsp_id, rsp_data, rsp_err);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (rsp_id !== e.id || rsp_data !== e.data || rsp_err !== e.err) begin
                        failed++;
                        $display("FAIL rsp_compare: got id=%0d data=%h err=%0d, required id=%0d data=%h err=%0d",
                                 rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
                    end
                end
            end
        end
    end

    task automatic wait_accept(input bit which, output int at);
        at = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if ((which ? req1_ready : req0_ready) === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_rsp(output int at);
        at = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && busy === 1'b0 && rsp_valid === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        tests++;
        if (!done) begin
            failed++;
            $display("FAIL %s_drain: got %0d pending responses busy=%0d, required 0 pending and idle",
                     name, sb.size(), busy);
        end
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] got[10];
        string            names[10];
        rst_n      = 1'b0;
        req0_valid = 1'b0; req0_data1 = '0; req0_data2 = '0; req0_ctrl = 3'b000;
        req1_valid = 1'b0; req1_data1 = '0; req1_data2 = '0; req1_ctrl = 3'b000;
        rsp_ready  = 1'b0;
        repeat (3) @(negedge clk);
        got[0] = WIDTH'(busy);       names[0] = "reset_busy";
        got[1] = WIDTH'(rsp_valid);  names[1] = "reset_rsp_valid";
        got[2] = rsp_data;           names[2] = "reset_rsp_data";
        got[3] = WIDTH'(rsp_id);     names[3] = "reset_rsp_id";
        got[4] = WIDTH'(rsp_err);    names[4] = "reset_rsp_err";
        got[5] = alu_data1;          names[5] = "reset_alu_data1";
        got[6] = alu_data2;          names[6] = "reset_alu_data2";
        got[7] = WIDTH'(alu_ctrl);   names[7] = "reset_alu_ctrl";
        got[8] = WIDTH'(req0_ready); names[8] = "reset_req0_ready";
        got[9] = WIDTH'(req1_ready); names[9] = "reset_req1_ready";
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (got[i] !== '0) begin
                failed++;
                $display("FAIL %s: got %h, required 0", names[i], got[i]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int d, n, r;
        @(posedge clk); #1;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_data1 = 32'd5; req0_data2 = 32'd7; req0_ctrl = 3'b010;
        d = cyc;
        wait_accept(1'b0, n);
        tests++;
        if (n !== d) begin
            failed++;
            $display("FAIL add_accept_cycle: got %0d, required %0d", n, d);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_rsp(r);
        tests++;
        if (r !== n + 2) begin
            failed++;
            $display("FAIL add_rsp_cycle: got %0d, required %0d", r, n + 2);
        end
        tests++;
        if (rsp_data !== 32'd12 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
            failed++;
            $display("FAIL add_rsp_fields: got data=%h id=%0d err=%0d, required data=0000000c id=0 err=0",
                     rsp_data, rsp_id, rsp_err);
        end
        drain("add");
    endtask

    task automatic test_mul_latency();
        int  d, n;
        bit  busy_ok, valid_ok;
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_data1 = 32'h0001_0000; req1_data2 = 32'h0001_0000; req1_ctrl = 3'b111;
        d = cyc;
        wait_accept(1'b1, n);
        tests++;
        if (n !== d) begin
            failed++;
            $display("FAIL mul_accept_cycle: got %0d, required %0d", n, d);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        busy_ok  = 1'b1;
        valid_ok = 1'b1;
        for (int i = 1; i <= MUL_LAT + 1; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (rsp_valid !== (i == MUL_LAT + 1)) valid_ok = 1'b0;
        end
        tests++;
        if (!busy_ok) begin
            failed++;
            $display("FAIL mul_busy_window: got a low busy in N+1..N+%0d, required high", MUL_LAT + 1);
        end
        tests++;
        if (!valid_ok) begin
            failed++;
            $display("FAIL mul_rsp_timing: got rsp_valid outside cycle N+%0d, required only at N+%0d",
                     MUL_LAT + 1, MUL_LAT + 1);
        end
        tests++;
        if (rsp_data !== 32'd0 || rsp_id !== 1'b1) begin
            failed++;
            $display("FAIL mul_wrap: got data=%h id=%0d, required data=00000000 id=1", rsp_data, rsp_id);
        end
        drain("mul");
    endtask

    task automatic test_round_robin();
        bit grants[4];
        int ng;
        bit both;
        ng   = 0;
        both = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_data1 = 32'd9;    req0_data2 = 32'd3;    req0_ctrl = 3'b110;
        req1_valid = 1'b1; req1_data1 = 32'hF0;   req1_data2 = 32'h0F;   req1_ctrl = 3'b001;
        for (int k = 0; k < 60 && ng < 4; k++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) both = 1'b1;
            if (req0_ready === 1'b1) begin
                grants[ng] = 1'b0; ng++;
            end else if (req1_ready === 1'b1) begin
                grants[ng] = 1'b1; ng++;
            end
            if (ng == 4) begin
                @(posedge clk); #1;
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        tests++;
        if (ng !== 4 || both) begin
            failed++;
            $display("FAIL rr_grant_count: got %0d grants (both_ready=%0d), required 4 single grants", ng, both);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (grants[i] !== i[0]) begin
                    failed++;
                    $display("FAIL rr_grant_%0d: got %0d, required %0d", i, grants[i], i[0]);
                end
            end
        end
        drain("rr");
    endtask

    task automatic test_illegal();
        int n, r;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_data1 = 32'h1234; req0_data2 = 32'h5678; req0_ctrl = 3'b011;
        wait_accept(1'b0, n);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (alu_ctrl !== 3'b010 || busy !== 1'b1) begin
            failed++;
            $display("FAIL illegal_exec_ctrl: got ctrl=%b busy=%0d, required ctrl=010 busy=1", alu_ctrl, busy);
        end
        wait_rsp(r);
        tests++;
        if (n < 0 || r !== n + 2) begin
            failed++;
            $display("FAIL illegal_rsp_cycle: got %0d, required %0d", r, n + 2);
        end
        tests++;
        if (rsp_err !== 1'b1 || rsp_data !== 32'd0) begin
            failed++;
            $display("FAIL illegal_rsp_fields: got err=%0d data=%h, required err=1 data=00000000",
                     rsp_err, rsp_data);
        end
        drain("illegal");
    endtask

    task automatic test_backpressure();
        int n, r;
        bit stable, no_ready;
        @(posedge clk); #1;
        rsp_ready  = 1'b0;
        req0_valid = 1'b1; req0_data1 = 32'hFF00; req0_data2 = 32'h0FF0; req0_ctrl = 3'b000;
        wait_accept(1'b0, n);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_data1 = 32'd1; req1_data2 = 32'd2; req1_ctrl = 3'b010;
        wait_rsp(r);
        tests++;
        if (n < 0 || r !== n + 2) begin
            failed++;
            $display("FAIL bp_rsp_cycle: got %0d, required %0d", r, n + 2);
        end
        stable   = 1'b1;
        no_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h0F00 || rsp_id !== 1'b0 || rsp_err !== 1'b0)
                stable = 1'b0;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) no_ready = 1'b0;
        end
        tests++;
        if (!stable) begin
            failed++;
            $display("FAIL bp_hold: got valid=%0d data=%h, required valid=1 data=00000f00 held 3 cycles",
                     rsp_valid, rsp_data);
        end
        tests++;
        if (!no_ready) begin
            failed++;
            $display("FAIL bp_no_ready: got a requester ready while stalled, required none");
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || req1_ready !== 1'b1) begin
            failed++;
            $display("FAIL bp_idle_after: got busy=%0d req1_ready=%0d, required busy=0 req1_ready=1",
                     busy, req1_ready);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        drain("bp");
    endtask

    task automatic test_reset_mid_mul();
        int n;
        bit quiet;
        @(posedge clk); #1;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_data1 = 32'd3; req0_data2 = 32'd4; req0_ctrl = 3'b111;
        wait_accept(1'b0, n);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || alu_data1 !== '0 || alu_data2 !== '0 || alu_ctrl !== 3'b000 ||
            rsp_valid !== 1'b0) begin
            failed++;
            $display("FAIL rst_async: got busy=%0d d1=%h d2=%h ctrl=%b rsp_valid=%0d, required all 0",
                     busy, alu_data1, alu_data2, alu_ctrl, rsp_valid);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < MUL_LAT + 4; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        tests++;
        if (!quiet) begin
            failed++;
            $display("FAIL rst_dropped_op: got a response or busy after reset, required none");
        end
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_data1 = 32'd3;  req0_data2 = 32'd4;  req0_ctrl = 3'b010;
        req1_valid = 1'b1; req1_data1 = 32'h30; req1_data2 = 32'h03; req1_ctrl = 3'b001;
        @(negedge clk);
        tests++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failed++;
            $display("FAIL rst_ptr: got req0_ready=%0d req1_ready=%0d, required 1 and 0",
                     req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain("rst");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add();
        test_mul_latency();
        test_round_robin();
        test_illegal();
        test_backpressure();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters, e.g. the main pipeline EX stage and an auxiliary address/loop unit.
- Arbitrates round-robin and drives the ALU operand and control inputs from latched registers.
- Holds a multiply for MUL_LAT cycles so mul can be multi-cycle timed; all other ops take 1 cycle.
- Returns each result on a valid/ready response channel tagged with the requester id.

Parameters:
- WIDTH, 32: operand and result width.
- MUL_LAT, 4: EXEC cycles for ctrl 3'b111. Legal range 1..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- req0_valid_i  in  1  requester 0 has an operation.
- req0_ready_o  out  1  requester 0 accepted this cycle.
- req0_data1_i  in  WIDTH  requester 0 operand 1.
- req0_data2_i  in  WIDTH  requester 0 operand 2.
- req0_ctrl_i  in  3  requester 0 ALU control code.
- req1_valid_i, req1_ready_o, req1_data1_i, req1_data2_i, req1_ctrl_i: same as requester 0, for requester 1.
- alu_data1_o  out  WIDTH  to ALU data1_i.
- alu_data2_o  out  WIDTH  to ALU data2_i.
- alu_ctrl_o  out  3  to ALU ALUCtrl_i.
- alu_data_i  in  WIDTH  from ALU data_o.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  consumer takes response.
- rsp_id_o  out  1  requester id of the response.
- rsp_data_o  out  WIDTH  result.
- rsp_err_o  out  1  illegal ctrl code was issued.
- busy_o  out  1  state != IDLE.

Behaviour:
Reset (rst_i low, asynchronous, any time):
- State goes to IDLE; round-robin pointer is 0 (requester 0 has priority).
- All registered outputs are 0: alu_* operands, alu_ctrl_o, rsp_*, busy_o.
- An in-flight op is dropped and no response is produced.

Legal codes and latency:
- Legal codes: 000 and, 001 or, 010 add, 110 sub, 111 mul.
- lat = MUL_LAT for 111, 1 for every other code.

States:
- IDLE:
  - grant = the pointer's requester if it is valid, else the other one if valid.
  - reqK_ready_o = (state==IDLE) && grant==K. It is combinational and may depend on the other requester's valid. At most one ready is high per cycle.
  - On accept, latch data1/data2/ctrl into the operand registers and latch id.
  - Load cnt = lat-1, set pointer = ~id, go to EXEC.
- EXEC:
  - alu_*_o drive the latched values.
  - If cnt != 0, decrement cnt.
  - If cnt == 0, capture rsp_data_o = alu_data_i and rsp_id_o = id, set rsp_valid_o = 1, go to RESP.
- RESP:
  - rsp_* are held stable while rsp_ready_i is low.
  - When rsp_ready_i is high, clear rsp_valid_o and go to IDLE.
  - No accept occurs in the RESP cycle.
- Operand hold: alu_*_o hold their last latched value outside EXEC and never toggle in IDLE or RESP.

Illegal ctrl codes:
- The op is accepted and takes lat = 1.
- alu_ctrl_o is forced to 010.
- The response carries rsp_data_o = 0 and rsp_err_o = 1.
- rsp_err_o is 0 for legal codes and is updated together with rsp_data_o.

Timing:
- Accept at the clock edge ending cycle N.
- EXEC occupies cycles N+1 .. N+lat.
- rsp_valid_o is high from cycle N+lat+1.
- Earliest next accept is the cycle after the response handshake.

Arithmetic: no widening. Result is the ALU's WIDTH-bit output unmodified (add/sub/mul wrap modulo 2^WIDTH).

Simultaneous events:
- Both valid in IDLE: the pointer wins and the loser waits; its inputs must stay stable.
- Valid deasserted before ready: no accept, no state change.
- rsp_ready_i high in EXEC: ignored.

Test Plan:
- Reset, then req0 add 5+7 -> req0_ready_o is high in cycle N, rsp_valid_o is high in N+2, rsp_data_o=12, rsp_id_o=0, rsp_err_o=0.
- req1 mul 0x0001_0000*0x0001_0000 with MUL_LAT=4 -> rsp_valid_o is high in N+5, rsp_data_o=0 (wrap), busy_o high N+1..N+5.
- Both requesters continuously valid with sub 9-3 (req0) and or 0xF0|0x0F (req1) -> grants alternate 0,1,0,1 and responses are 6,0xFF,6,0xFF with matching ids.
- ctrl=3'b011 from req0 -> response rsp_err_o=1, rsp_data_o=0, alu_ctrl_o=010 during EXEC.
- Hold rsp_ready_i low 3 cycles after an and 0xFF00&0x0FF0 -> rsp_valid_o and rsp_data_o=0x0F00 are stable throughout, no ready to any requester, IDLE the cycle after the handshake.
- Assert rst_i low mid-EXEC of a mul -> all outputs 0 immediately (asynchronously, without waiting for a clock edge), no response after release, next grant goes to req0.
